// File: rtl/bit_slice_alu_8bit_if.sv
// bit_slice_alu_8bit_if: operand/op-select inputs and registered result/flag outputs
// of the bit-slice ALU, with master (driver) and slave (ALU) views.
`default_nettype none

interface bit_slice_alu_8bit_if;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic        bin;
  logic [4:0]  sel;
  logic [15:0] z;
  logic        carry;
  logic        overflow;
  logic        negative;
  logic        zero;

  modport master (
    output a, b, cin, bin, sel,
    input  z, carry, overflow, negative, zero
  );

  modport slave (
    input  a, b, cin, bin, sel,
    output z, carry, overflow, negative, zero
  );
endinterface

`default_nettype wire

// File: rtl/bit_slice_alu_8bit.sv
// bit_slice_alu_8bit: eight ripple-connected 1-bit add/sub slices, AND/OR/XOR and an
// 8x8 unsigned/signed multiplier; 16-bit result and N/Z/C/V flags registered (1 cycle).
`default_nettype none

module bit_slice_alu_8bit (
  input  wire logic          clk,
  input  wire logic          rst,
  bit_slice_alu_8bit_if.slave alu
);

  localparam logic [4:0] SEL_ADD  = 5'b00001;
  localparam logic [4:0] SEL_SUB  = 5'b00010;
  localparam logic [4:0] SEL_AND  = 5'b00100;
  localparam logic [4:0] SEL_OR   = 5'b01000;
  localparam logic [4:0] SEL_XOR  = 5'b10000;
  localparam logic [4:0] SEL_MULU = 5'b00000;
  localparam logic [4:0] SEL_MULS = 5'b11111;

  logic        w_is_sub;
  logic [8:0]  w_c;
  logic [7:0]  w_s;

  assign w_is_sub = (alu.sel == SEL_SUB);
  assign w_c[0]   = w_is_sub ? alu.bin : alu.cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      logic w_bb;
      assign w_bb       = w_is_sub ? ~alu.b[gi] : alu.b[gi];
      assign w_s[gi]    = alu.a[gi] ^ w_bb ^ w_c[gi];
      assign w_c[gi+1]  = (alu.a[gi] & w_bb) | (alu.a[gi] & w_c[gi]) | (w_bb & w_c[gi]);
    end
  endgenerate

  // Signed multiply: multiply magnitudes, then negate when operand signs differ.
  // |-128| = 128 still fits an 8-bit unsigned magnitude, so -128*-128 is exact.
  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [7:0]  w_mag_a;
  logic [7:0]  w_mag_b;
  logic [15:0] w_prod_u;
  logic [15:0] w_prod;

  assign w_signed = (alu.sel == SEL_MULS);
  assign w_neg_a  = w_signed & alu.a[7];
  assign w_neg_b  = w_signed & alu.b[7];
  assign w_mag_a  = w_neg_a ? (8'd0 - alu.a) : alu.a;
  assign w_mag_b  = w_neg_b ? (8'd0 - alu.b) : alu.b;
  assign w_prod_u = {8'h00, w_mag_a} * {8'h00, w_mag_b};
  assign w_prod   = (w_neg_a ^ w_neg_b) ? (16'd0 - w_prod_u) : w_prod_u;

  logic [15:0] z_d;
  logic        carry_d;
  logic        overflow_d;
  logic        negative_d;
  logic        zero_d;

  always_comb begin
    z_d        = 16'h0000;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    negative_d = 1'b0;
    unique case (alu.sel)
      SEL_ADD: begin
        z_d        = {8'h00, w_s};
        carry_d    = w_c[8];
        overflow_d = w_c[8] ^ w_c[7];
        negative_d = w_s[7];
      end
      SEL_SUB: begin
        z_d        = {8'h00, w_s};
        carry_d    = ~w_c[8];
        overflow_d = w_c[8] ^ w_c[7];
        negative_d = w_s[7];
      end
      SEL_AND: begin
        z_d        = {8'h00, alu.a & alu.b};
        negative_d = alu.a[7] & alu.b[7];
      end
      SEL_OR: begin
        z_d        = {8'h00, alu.a | alu.b};
        negative_d = alu.a[7] | alu.b[7];
      end
      SEL_XOR: begin
        z_d        = {8'h00, alu.a ^ alu.b};
        negative_d = alu.a[7] ^ alu.b[7];
      end
      SEL_MULU: begin
        z_d        = w_prod;
      end
      SEL_MULS: begin
        z_d        = w_prod;
        negative_d = w_prod[15];
      end
      default: begin
        z_d        = 16'h0000;
      end
    endcase
    zero_d = (z_d == 16'h0000);
  end

  logic [15:0] z_q;
  logic        carry_q;
  logic        overflow_q;
  logic        negative_q;
  logic        zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q        <= 16'h0000;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      z_q        <= z_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
      zero_q     <= zero_d;
    end
  end

  assign alu.z        = z_q;
  assign alu.carry    = carry_q;
  assign alu.overflow = overflow_q;
  assign alu.negative = negative_q;
  assign alu.zero     = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_slice_alu_8bit.sv
// tb_bit_slice_alu_8bit: scoreboard bench; expected {z,C,V,N,Z} queued at drive time,
// popped one cycle later when the registered result is sampled.
`default_nettype none

module tb_bit_slice_alu_8bit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  bit_slice_alu_8bit_if alu_bus ();

  bit_slice_alu_8bit dut (
    .clk (clk),
    .rst (rst),
    .alu (alu_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got z=%h CVNZ=%b, expected z=%h CVNZ=%b",
               tag, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  // Reference model packed as {z[15:0], carry, overflow, negative, zero}.
  function automatic logic [19:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic bi,
                                        input logic [4:0] sel);
    logic [15:0] z;
    logic        c, v, n;
    logic [8:0]  t;
    int          sa, sb, p;
    z = 16'h0; c = 1'b0; v = 1'b0; n = 1'b0;
    case (sel)
      5'b00001: begin
        t = {1'b0, a} + {1'b0, b} + {8'h00, ci};
        z = {8'h00, t[7:0]}; c = t[8]; n = t[7];
        v = (a[7] == b[7]) && (t[7] != a[7]);
      end
      5'b00010: begin
        t = {1'b0, a} + {1'b0, ~b} + {8'h00, bi};
        z = {8'h00, t[7:0]}; c = ~t[8]; n = t[7];
        v = (a[7] != b[7]) && (t[7] != a[7]);
      end
      5'b00100: begin z = {8'h00, a & b}; n = z[7]; end
      5'b01000: begin z = {8'h00, a | b}; n = z[7]; end
      5'b10000: begin z = {8'h00, a ^ b}; n = z[7]; end
      5'b00000: z = {8'h00, a} * {8'h00, b};
      5'b11111: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        z  = p[15:0];
        n  = z[15];
      end
      default: z = 16'h0;
    endcase
    return {z, c, v, n, (z == 16'h0000)};
  endfunction

  task automatic drive_exp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic bi, input logic [4:0] sel,
                           input logic r, input logic [19:0] exp);
    sb_item_t it;
    @(negedge clk);
    alu_bus.a   = a;
    alu_bus.b   = b;
    alu_bus.cin = ci;
    alu_bus.bin = bi;
    alu_bus.sel = sel;
    rst         = r;
    it.tag      = tag;
    it.exp      = exp;
    sb_q.push_back(it);
  endtask

  task automatic drive(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic bi, input logic [4:0] sel);
    drive_exp(tag, a, b, ci, bi, sel, 1'b0, model(a, b, ci, bi, sel));
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      sb_item_t it;
      it = sb_q.pop_front();
      chk(it.tag, {alu_bus.z, alu_bus.carry, alu_bus.overflow,
                   alu_bus.negative, alu_bus.zero}, it.exp);
    end
  end

  logic [4:0] sel_tab [0:8] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                5'b00000, 5'b11111, 5'b00011, 5'b10100};

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    alu_bus.a = 8'h00; alu_bus.b = 8'h00; alu_bus.cin = 1'b0;
    alu_bus.bin = 1'b0; alu_bus.sel = 5'b00001;

    drive_exp("reset0", 8'hFF, 8'h01, 1'b1, 1'b1, 5'b00001, 1'b1, 20'h0);
    drive_exp("reset1", 8'h7F, 8'h7F, 1'b0, 1'b0, 5'b11111, 1'b1, 20'h0);

    drive_exp("add_f0_0f",  8'hF0, 8'h0F, 1'b0, 1'b0, 5'b00001, 1'b0, {16'h00FF, 4'b0010});
    drive_exp("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 5'b00001, 1'b0, {16'h0000, 4'b1001});
    drive_exp("add_cin",    8'h10, 8'h20, 1'b1, 1'b0, 5'b00001, 1'b0, {16'h0031, 4'b0000});
    drive_exp("sub_0f_0f",  8'h0F, 8'h0F, 1'b0, 1'b1, 5'b00010, 1'b0, {16'h0000, 4'b0001});
    drive_exp("sub_00_01",  8'h00, 8'h01, 1'b1, 1'b1, 5'b00010, 1'b0, {16'h00FF, 4'b1010});
    drive_exp("sub_bin0",   8'h05, 8'h02, 1'b0, 1'b0, 5'b00010, 1'b0, {16'h0002, 4'b0000});
    drive_exp("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 5'b00010, 1'b0, {16'h007F, 4'b0100});
    drive_exp("add_7f_7f",  8'h7F, 8'h7F, 1'b0, 1'b0, 5'b00001, 1'b0, {16'h00FE, 4'b0110});
    drive_exp("and_56_65",  8'h56, 8'h65, 1'b1, 1'b1, 5'b00100, 1'b0, {16'h0044, 4'b0000});
    drive_exp("or_56_65",   8'h56, 8'h65, 1'b1, 1'b1, 5'b01000, 1'b0, {16'h0077, 4'b0000});
    drive_exp("xor_56_65",  8'h56, 8'h65, 1'b1, 1'b1, 5'b10000, 1'b0, {16'h0033, 4'b0000});
    drive_exp("or_neg",     8'h80, 8'h01, 1'b0, 1'b0, 5'b01000, 1'b0, {16'h0081, 4'b0010});
    drive_exp("mulu_40_ff", 8'h40, 8'hFF, 1'b1, 1'b1, 5'b00000, 1'b0, {16'h3FC0, 4'b0000});
    drive_exp("mulu_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 5'b00000, 1'b0, {16'hFE01, 4'b0000});
    drive_exp("muls_40_40", 8'h40, 8'h40, 1'b0, 1'b0, 5'b11111, 1'b0, {16'h1000, 4'b0000});
    drive_exp("muls_40_b2", 8'h40, 8'hB2, 1'b0, 1'b0, 5'b11111, 1'b0, {16'hEC80, 4'b0010});
    drive_exp("muls_b2_b2", 8'hB2, 8'hB2, 1'b0, 1'b0, 5'b11111, 1'b0, {16'h17C4, 4'b0000});
    drive_exp("muls_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 5'b11111, 1'b0, {16'h4000, 4'b0000});
    drive_exp("muls_zero",  8'h00, 8'h9C, 1'b0, 1'b0, 5'b11111, 1'b0, {16'h0000, 4'b0001});
    drive_exp("bad_sel",    8'h12, 8'h34, 1'b1, 1'b1, 5'b00011, 1'b0, {16'h0000, 4'b0001});

    drive_exp("pre_rst",    8'hFF, 8'h01, 1'b0, 1'b0, 5'b00001, 1'b0, {16'h0000, 4'b1001});
    drive_exp("mid_rst",    8'hFF, 8'h01, 1'b0, 1'b0, 5'b00001, 1'b1, 20'h0);
    drive_exp("post_rst",   8'hFF, 8'h01, 1'b0, 1'b0, 5'b00001, 1'b0, {16'h0000, 4'b1001});

    for (int i = 0; i < 60; i++) begin
      drive("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            sel_tab[$urandom_range(0, 8)]);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
